// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sequencer state encoding and the index-width calculation.
package rf_pkg;

   typedef enum logic {
      RF_IDLE,
      RF_CLEAR
   } rf_state_e;

   function automatic int calc_aw(input int nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared by writeback, flushed in bulk.
// Bit 0 is never pending; a set wins over a same-cycle writeback clear.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   localparam int AW    = calc_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_addr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] lk_addr,
   output logic [NRD-1:0]    lk_pend
);

   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;

   // NOTE: pend_d starts as a copy of pend_q so every path assigns it and no latch is inferred.
   always_comb begin
      pend_d = pend_q;
      if (clr_en) pend_d[clr_addr] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
      if (flush)  pend_d = '0;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   always_comb begin
      lk_pend = '0;
      for (int k = 0; k < NRD; k++) lk_pend[k] = pend_q[lk_addr[k*AW +: AW]];
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass, pending scoreboard
// and a sequenced bulk-clear engine that zeroes one register per cycle.
module regfile_mp
   import rf_pkg::*;
#(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = calc_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   output logic                wr_ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pend,
   input  logic                pend_set,
   input  logic [AW-1:0]       pend_addr,
   input  logic                clr_req,
   output logic                busy,
   output logic                clr_done
);

   localparam logic [AW-1:0] PTR_LAST = AW'(NREGS - 1);

   rf_state_e       state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            clr_done_q, clr_done_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            flush;
   logic            wr_acc;

   assign busy     = (state_q == RF_CLEAR);
   assign wr_ready = !busy;
   assign clr_done = clr_done_q;
   assign wr_acc   = wr_en && wr_ready && (wr_addr != '0);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clr_done_d = 1'b0;
      flush      = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (clr_req) begin
               state_d = RF_CLEAR;
               ptr_d   = AW'(1);
               flush   = 1'b1;
            end
         end
         RF_CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == PTR_LAST) begin
               state_d    = RF_IDLE;
               clr_done_d = 1'b1;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   // Writes never coincide with the clear sweep because wr_ready is low while busy.
   always_comb begin
      regs_d = regs_q;
      if (wr_acc) regs_d[wr_addr] = wr_data;
      if (busy)   regs_d[ptr_q]   = '0;
      regs_d[0] = '0;
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RF_IDLE;
         ptr_q      <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         clr_done_q <= clr_done_d;
      end
   end

   // NOTE: the array is reset on purpose; software relies on every register reading zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] val;
      assign idx = rd_addr[k*AW +: AW];
      always_comb begin
         if (idx == '0)                                val = '0;
         else if (BYPASS && wr_acc && (wr_addr == idx)) val = wr_data;
         else                                           val = regs_q[idx];
      end
      assign rd_data[k*XLEN +: XLEN] = val;
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (pend_set && !busy),
      .set_addr (pend_addr),
      .clr_en   (wr_acc),
      .clr_addr (wr_addr),
      .flush    (flush),
      .lk_addr  (rd_addr),
      .lk_pend  (rd_pend)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic,
// compared every cycle against an array-based behavioural model.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 3;
   localparam int AW    = 5;

   logic                clk;
   logic                rst_n;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_pend;
   logic                pend_set;
   logic [AW-1:0]       pend_addr;
   logic                clr_req;
   logic                busy;
   logic                clr_done;

   regfile_mp #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NRD    (NRD),
      .BYPASS (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_pend   (rd_pend),
      .pend_set  (pend_set),
      .pend_addr (pend_addr),
      .clr_req   (clr_req),
      .busy      (busy),
      .clr_done  (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] regs_m [NREGS];
   bit              pend_m [NREGS];
   bit              busy_m;
   bit              done_m;
   int              ptr_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         regs_m[i] = '0;
         pend_m[i] = 1'b0;
      end
      busy_m = 1'b0;
      done_m = 1'b0;
      ptr_m  = 0;
   endtask

   // One clock edge of architectural behaviour, from the current inputs.
   task automatic model_update();
      done_m = 1'b0;
      if (busy_m) begin
         regs_m[ptr_m] = '0;
         ptr_m++;
         if (ptr_m == NREGS) begin
            busy_m = 1'b0;
            done_m = 1'b1;
         end
      end else begin
         if (wr_en && wr_addr != 0) begin
            regs_m[wr_addr] = wr_data;
            pend_m[wr_addr] = 1'b0;
         end
         if (pend_set && pend_addr != 0) pend_m[pend_addr] = 1'b1;
         if (clr_req) begin
            busy_m = 1'b1;
            ptr_m  = 1;
            for (int i = 0; i < NREGS; i++) pend_m[i] = 1'b0;
         end
      end
   endtask

   function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (!busy_m && wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
      return regs_m[a];
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NRD; k++) begin
         logic [AW-1:0] a;
         a = rd_addr[k*AW +: AW];
         check($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], model_read(a));
         check($sformatf("rd_pend%0d", k), 32'(rd_pend[k]), 32'(pend_m[a]));
      end
      check("busy", 32'(busy), 32'(busy_m));
      check("wr_ready", 32'(wr_ready), 32'(!busy_m));
      check("clr_done", 32'(clr_done), 32'(done_m));
   end

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
   endtask

   task automatic set_rd(input int a0, input int a1, input int a2);
      rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic quiet();
      wr_en    = 1'b0;
      pend_set = 1'b0;
      clr_req  = 1'b0;
   endtask

   task automatic fill_all();
      for (int i = 1; i < NREGS; i++) begin
         wr_en     = 1'b1;
         wr_addr   = AW'(i);
         wr_data   = 32'h0101_0101 * i;
         pend_set  = (i % 3 == 0);
         pend_addr = AW'(i ^ 1);
         cycle();
      end
      quiet();
   endtask

   task automatic read_all_zero(input string tag);
      for (int b = 0; b < 11; b++) begin
         set_rd((3*b) % NREGS, (3*b+1) % NREGS, (3*b+2) % NREGS);
         #1;
         for (int k = 0; k < NRD; k++) begin
            check($sformatf("%s_data%0d", tag, k), rd_data[k*XLEN +: XLEN], 32'h0);
            check($sformatf("%s_pend%0d", tag, k), 32'(rd_pend[k]), 32'h0);
         end
         cycle();
      end
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;

      rst_n = 1'b0;
      quiet();
      wr_addr = '0;
      wr_data = '0;
      pend_addr = '0;
      set_rd(0, 0, 0);
      model_reset();
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_wr_ready", 32'(wr_ready), 32'h1);
      check("rst_clr_done", 32'(clr_done), 32'h0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      // Bypass and array read of x5.
      wr_en = 1'b1; wr_addr = 5; wr_data = 32'hABCD_E123;
      set_rd(0, 5, 0);
      #1 check("bypass_x5", rd_data[XLEN +: XLEN], 32'hABCD_E123);
      cycle();
      wr_en = 1'b0;
      set_rd(5, 0, 0);
      #1 check("read_x5", rd_data[0 +: XLEN], 32'hABCD_E123);
      cycle();

      // x0 is hardwired zero.
      wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEAD_BEEF;
      set_rd(0, 0, 0);
      #1 check("x0_same", rd_data, '0);
      cycle();
      wr_en = 1'b0;
      #1 check("x0_next", rd_data, '0);
      cycle();

      // Three simultaneous reads.
      wr_en = 1'b1;
      wr_addr = 10; wr_data = 111; cycle();
      wr_addr = 20; wr_data = 222; cycle();
      wr_addr = 31; wr_data = 333; cycle();
      wr_en = 1'b0;
      set_rd(10, 20, 31);
      #1;
      check("rd3_p0", rd_data[0 +: XLEN], 32'd111);
      check("rd3_p1", rd_data[XLEN +: XLEN], 32'd222);
      check("rd3_p2", rd_data[2*XLEN +: XLEN], 32'd333);
      cycle();

      // Scoreboard set, clear by writeback, set-wins.
      pend_set = 1'b1; pend_addr = 7; set_rd(7, 9, 0);
      cycle();
      pend_set = 1'b0;
      #1 check("pend_x7_set", 32'(rd_pend[0]), 32'h1);
      wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77;
      cycle();
      wr_en = 1'b0;
      #1 check("pend_x7_clr", 32'(rd_pend[0]), 32'h0);
      wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; pend_set = 1'b1; pend_addr = 9;
      cycle();
      quiet();
      #1 check("pend_x9_setwins", 32'(rd_pend[1]), 32'h1);
      cycle();

      // Full clear sequence.
      fill_all();
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         wr_en = (i < 5); wr_addr = 3; wr_data = 32'h5555_5555;
         pend_set = (i < 5); pend_addr = 6;
         #1;
         if (i == 0) check("clr_wr_ready", 32'(wr_ready), 32'h0);
         if (busy) busy_cnt++;
         if (clr_done) done_cnt++;
         cycle();
      end
      quiet();
      check("clr_busy_cycles", busy_cnt, 32'd31);
      check("clr_done_pulses", done_cnt, 32'd1);
      read_all_zero("clr");

      // Reset during the sweep.
      fill_all();
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(clr_done), 32'h0);
      cycle();
      cycle();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         #1 if (clr_done) done_cnt++;
         cycle();
      end
      check("abort_no_done", done_cnt, 32'd0);
      read_all_zero("abort");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         wr_en     = $urandom_range(0, 1) != 0;
         wr_addr   = AW'($urandom_range(0, NREGS - 1));
         wr_data   = $urandom;
         clr_req   = ($urandom_range(0, 79) == 0);
         pend_set  = ($urandom_range(0, 3) == 0) && !clr_req;
         pend_addr = AW'($urandom_range(0, NREGS - 1));
         set_rd($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                $urandom_range(0, NREGS - 1));
         if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = wr_addr;
         cycle();
      end
      quiet();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
